stall_ctrl: RTL and testbench
=============================

STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 Parameter MULT_CYC, default 5, meaning busy cycles for a multiply.
REQ-002 Parameter DIV_CYC, default 10, meaning busy cycles for a divide.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ld_use  input  1  the D-stage instruction reads a GPR that the E-stage load writes.
REQ-006 md_start  input  1  a valid mult, multu, div or divu instruction is in E this cycle.
REQ-007 md_is_div  input  1  qualifies md_start: 1 means div/divu, 0 means mult/multu.
REQ-008 md_use_D  input  1  the D-stage instruction is mfhi, mflo, mthi, mtlo, mult, multu, div or divu.
REQ-009 PC_EN  output  1  PC write enable.
REQ-010 D_EN  output  1  F/D pipeline register write enable.
REQ-011 E_CLR  output  1  synchronous clear of the D/E pipeline register, which inserts a bubble.
REQ-012 BUSY  output  1  the multiply/divide unit is executing.
REQ-013 MD_DONE  output  1  single-cycle pulse on the last busy cycle.
REQ-014 STALL_CNT  output  16  saturating count of stall cycles.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, MULT, DIV.
REQ-016 A 4-bit down-counter cnt SHALL hold the remaining busy cycles.
REQ-017 In IDLE with md_start=1, the next state SHALL be DIV with cnt=DIV_CYC if md_is_div=1, else MULT with cnt=MULT_CYC.
REQ-018 In IDLE with md_start=0, the FSM SHALL remain in IDLE and cnt SHALL remain 0.
REQ-019 In MULT or DIV with cnt>1, cnt SHALL decrement by 1 per cycle.
REQ-020 In MULT or DIV with cnt==1, the next state SHALL be IDLE and cnt SHALL become 0.
REQ-021 In MULT or DIV, md_start SHALL be ignored, with no restart and no counter reload.
REQ-022 BUSY SHALL be 1 exactly when the state is not IDLE, so BUSY is high for MULT_CYC or DIV_CYC consecutive cycles starting the cycle after md_start.
REQ-023 MD_DONE SHALL be 1 exactly when the state is not IDLE and cnt==1 (combinational).
REQ-024 md_stall SHALL equal md_use_D AND (BUSY OR md_start).
REQ-025 stall SHALL equal ld_use OR md_stall.
REQ-026 PC_EN and D_EN SHALL equal NOT stall (combinational, same cycle).
REQ-027 E_CLR SHALL equal stall (combinational, same cycle).
REQ-028 Simultaneous ld_use and md_stall SHALL produce a single stall for that cycle, counted once.
REQ-029 STALL_CNT SHALL increment by 1 on each rising edge where stall=1.
REQ-030 STALL_CNT SHALL saturate at 16'hFFFF and SHALL NOT wrap to 0.
REQ-031 In the cycle where MD_DONE=1, md_stall SHALL still be asserted if md_use_D=1; the dependent instruction SHALL proceed in the following cycle.

Reset
REQ-032 On reset=1, independent of clk, the state SHALL be IDLE, cnt SHALL be 0 and STALL_CNT SHALL be 0.
REQ-033 While reset=1, BUSY=0 and MD_DONE=0.
REQ-034 While reset=1, PC_EN, D_EN and E_CLR SHALL follow REQ-026 and REQ-027 from the inputs, since they are combinational.
REQ-035 Reset asserted mid-operation (MULT or DIV) SHALL abort the operation immediately with no MD_DONE pulse.
REQ-036 After reset deasserts, md_start on the first rising edge SHALL be accepted normally.

Verification
REQ-037 Scenario: md_start=1, md_is_div=0 for one cycle -> BUSY=1 for exactly 5 cycles, MD_DONE=1 on the 5th only, then IDLE.
REQ-038 Scenario: div start followed by md_use_D=1 held -> PC_EN=D_EN=0 and E_CLR=1 for 11 cycles (the start cycle plus 10 busy cycles), then PC_EN=1, with STALL_CNT=11.
REQ-039 Scenario: ld_use=1 for 1 cycle with no multiply/divide activity -> exactly one stall cycle, STALL_CNT increments by 1, and BUSY stays 0.
REQ-040 Scenario: during MULT with cnt=3, pulse md_start with md_is_div=1 -> no reload, BUSY drops after 3 more cycles, and DIV is never entered.
REQ-041 Scenario: reset asserted asynchronously between clock edges during DIV with cnt=6 -> BUSY=0 and STALL_CNT=0 immediately, and MD_DONE never pulses.
REQ-042 Scenario: force stall=1 for 65540 cycles -> STALL_CNT holds 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: load-use and multiply/divide hazards, a small
// mult/div busy sequencer, and a saturating count of stall cycles.
module stall_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_use,
  input  logic        md_start,
  input  logic        md_is_div,
  input  logic        md_use_D,
  output logic        PC_EN,
  output logic        D_EN,
  output logic        E_CLR,
  output logic        BUSY,
  output logic        MD_DONE,
  output logic [15:0] STALL_CNT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2
  } state_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

  state_t     state;
  logic [3:0] cnt;
  logic       md_stall;
  logic       stall;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (md_start) begin
            state <= md_is_div ? DIV : MULT;
            cnt   <= md_is_div ? DIV_LOAD : MULT_LOAD;
          end
        end
        MULT, DIV: begin
          // A new md_start while busy is ignored: no restart, no reload.
          if (cnt > 4'd1) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= IDLE;
            cnt   <= 4'd0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign BUSY    = (state != IDLE);
  assign MD_DONE = BUSY && (cnt == 4'd1);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    md_stall = 1'b0;
    stall    = 1'b0;
    md_stall = md_use_D && (BUSY || md_start);
    stall    = ld_use || md_stall;
  end

  assign PC_EN = ~stall;
  assign D_EN  = ~stall;
  assign E_CLR = stall;

  // Saturates at all-ones; a simultaneous load-use and mult/div stall is one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      STALL_CNT <= 16'd0;
    end else if (stall && (STALL_CNT != 16'hFFFF)) begin
      STALL_CNT <= STALL_CNT + 16'd1;
    end
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: a timeline model (busy window per
// accepted start, saturating stall tally) plus directed scenarios.
module tb_stall_ctrl;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_use, md_start, md_is_div, md_use_D;
  logic        PC_EN, D_EN, E_CLR, BUSY, MD_DONE;
  logic [15:0] STALL_CNT;

  stall_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk       (clk),
    .reset     (reset),
    .ld_use    (ld_use),
    .md_start  (md_start),
    .md_is_div (md_is_div),
    .md_use_D  (md_use_D),
    .PC_EN     (PC_EN),
    .D_EN      (D_EN),
    .E_CLR     (E_CLR),
    .BUSY      (BUSY),
    .MD_DONE   (MD_DONE),
    .STALL_CNT (STALL_CNT)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: the unit is busy during cycle indices [busy_first, busy_last].
  longint cyc = 0;
  longint busy_first = 1;
  longint busy_last  = 0;
  int     model_cnt  = 0;

  logic        obs_busy, obs_done, obs_pc_en;
  logic [15:0] obs_cnt;

  task automatic model_reset();
    busy_first = cyc + 1;
    busy_last  = cyc;
    model_cnt  = 0;
  endtask

  // One clock cycle: drive at negedge, compare 1ns later, advance model at posedge.
  task automatic step(input logic lu, input logic ms, input logic dv,
                      input logic use_d, input bit chk);
    logic busy_m, done_m, stall_m;
    @(negedge clk);
    ld_use = lu; md_start = ms; md_is_div = dv; md_use_D = use_d;
    #1;
    busy_m  = (cyc >= busy_first) && (cyc <= busy_last);
    done_m  = busy_m && (cyc == busy_last);
    stall_m = lu | (use_d & (busy_m | ms));
    obs_busy = BUSY; obs_done = MD_DONE; obs_pc_en = PC_EN; obs_cnt = STALL_CNT;
    if (chk) begin
      n_checks += 6;
      if (BUSY !== busy_m) begin
        n_errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, BUSY, busy_m);
      end
      if (MD_DONE !== done_m) begin
        n_errors++; $display("FAIL md_done cyc=%0d got=%b exp=%b", cyc, MD_DONE, done_m);
      end
      if (PC_EN !== ~stall_m) begin
        n_errors++; $display("FAIL pc_en cyc=%0d got=%b exp=%b", cyc, PC_EN, ~stall_m);
      end
      if (D_EN !== ~stall_m) begin
        n_errors++; $display("FAIL d_en cyc=%0d got=%b exp=%b", cyc, D_EN, ~stall_m);
      end
      if (E_CLR !== stall_m) begin
        n_errors++; $display("FAIL e_clr cyc=%0d got=%b exp=%b", cyc, E_CLR, stall_m);
      end
      if (STALL_CNT !== 16'(model_cnt)) begin
        n_errors++; $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", cyc, STALL_CNT, model_cnt);
      end
    end
    @(posedge clk);
    if (!busy_m && ms) begin
      busy_first = cyc + 1;
      busy_last  = cyc + (dv ? DIV_CYC : MULT_CYC);
    end
    if (stall_m && model_cnt < 65535) model_cnt++;
    cyc++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; ld_use = 1'b0; md_start = 1'b0; md_is_div = 1'b0; md_use_D = 1'b0;
    #1;
    n_checks++;
    if (BUSY !== 1'b0 || MD_DONE !== 1'b0 || STALL_CNT !== 16'd0) begin
      n_errors++;
      $display("FAIL apply_reset busy=%b done=%b cnt=%0d exp 0/0/0", BUSY, MD_DONE, STALL_CNT);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1; ld_use = 1'b0; md_start = 1'b0; md_is_div = 1'b0; md_use_D = 1'b0;
    #1;
    n_checks++;
    if (BUSY !== 1'b0 || MD_DONE !== 1'b0 || STALL_CNT !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_state busy=%b done=%b cnt=%0d exp 0/0/0", BUSY, MD_DONE, STALL_CNT);
    end
    ld_use = 1'b1;
    #1;
    n_checks++;
    if (PC_EN !== 1'b0 || D_EN !== 1'b0 || E_CLR !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_comb_stall pc=%b d=%b eclr=%b exp 0/0/1", PC_EN, D_EN, E_CLR);
    end
    ld_use = 1'b0; md_start = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (BUSY !== 1'b0 || PC_EN !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_hold busy=%b pc=%b exp 0/1", BUSY, PC_EN);
    end
    @(negedge clk);
    reset = 1'b0; md_start = 1'b0;
    model_reset();
    // Start right on the first edge after release.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs_busy !== 1'b1) begin
      n_errors++; $display("FAIL first_edge_start busy=%b exp 1", obs_busy);
    end
    repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_mult();
    int nbusy = 0, ndone = 0, done_pos = 0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (obs_busy === 1'b1) nbusy++;
      if (obs_done === 1'b1) begin ndone++; done_pos = nbusy; end
    end
    n_checks += 3;
    if (nbusy != 5) begin n_errors++; $display("FAIL mult_busy_len got=%0d exp=5", nbusy); end
    if (ndone != 1) begin n_errors++; $display("FAIL mult_done_count got=%0d exp=1", ndone); end
    if (done_pos != 5) begin n_errors++; $display("FAIL mult_done_pos got=%0d exp=5", done_pos); end
  endtask

  task automatic test_div_stall();
    int nstall = 0;
    apply_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    if (obs_pc_en === 1'b0) nstall++;
    repeat (10) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      if (obs_pc_en === 1'b0) nstall++;
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks += 3;
    if (nstall != 11) begin n_errors++; $display("FAIL div_stall_len got=%0d exp=11", nstall); end
    if (obs_pc_en !== 1'b1) begin n_errors++; $display("FAIL div_release pc=%b exp 1", obs_pc_en); end
    if (obs_cnt !== 16'd11) begin n_errors++; $display("FAIL div_stall_cnt got=%0d exp=11", obs_cnt); end
  endtask

  task automatic test_ld_use();
    apply_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs_pc_en !== 1'b0 || obs_busy !== 1'b0) begin
      n_errors++; $display("FAIL ld_use_stall pc=%b busy=%b exp 0/0", obs_pc_en, obs_busy);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs_pc_en !== 1'b1 || obs_busy !== 1'b0 || obs_cnt !== 16'd1) begin
      n_errors++;
      $display("FAIL ld_use_after pc=%b busy=%b cnt=%0d exp 1/0/1", obs_pc_en, obs_busy, obs_cnt);
    end
  endtask

  task automatic test_no_reload();
    int nbusy = 0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    if (obs_busy === 1'b1) nbusy++;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (obs_busy === 1'b1) nbusy++;
    end
    n_checks++;
    if (nbusy != 3) begin n_errors++; $display("FAIL no_reload_busy got=%0d exp=3", nbusy); end
  endtask

  task automatic test_async_reset();
    int ndone = 0;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    ld_use = 1'b0; md_start = 1'b0; md_use_D = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (BUSY !== 1'b0 || STALL_CNT !== 16'd0 || MD_DONE !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset busy=%b cnt=%0d done=%b exp 0/0/0", BUSY, STALL_CNT, MD_DONE);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (MD_DONE === 1'b1 || BUSY === 1'b1) ndone++;
    end
    n_checks++;
    if (ndone != 0) begin n_errors++; $display("FAIL async_reset_done got=%0d exp=0", ndone); end
    @(negedge clk);
    reset = 1'b0; md_use_D = 1'b0;
    model_reset();
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(7) == 0), ($urandom_range(5) == 0), 1'($urandom_range(1)),
           ($urandom_range(2) == 0), 1'b1);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 65540; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, (i % 8192 == 0) || (i > 65530));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs_cnt !== 16'hFFFF) begin
      n_errors++; $display("FAIL saturation got=%h exp=ffff", obs_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_stall();
    test_ld_use();
    test_no_reload();
    test_async_reset();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
